// File: rtl/bsc_pkg.sv
// Shared types and elaboration limits for the bit_sample_counter receive-timing block.
package bsc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int OVERSAMPLE_MIN = 4;
  localparam int OVERSAMPLE_MAX = 64;
  localparam int FRAME_BITS_MIN = 2;
  localparam int FRAME_BITS_MAX = 16;

endpackage

// File: rtl/bit_sample_counter_if.sv
// Control and status bundle between the rx front end, the timing engine and the shift register.
interface bit_sample_counter_if #(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 10
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic             tick;
  logic             start;
  logic             abort;
  logic             rxd;
  logic             busy;
  logic [CNT_W-1:0] phase;
  logic [BIT_W-1:0] bit_num;
  logic             sample;
  logic             bit_done;
  logic             frame_done;
  logic             false_start;

  modport master (
    output tick, start, abort, rxd,
    input  busy, phase, bit_num, sample, bit_done, frame_done, false_start
  );

  modport slave (
    input  tick, start, abort, rxd,
    output busy, phase, bit_num, sample, bit_done, frame_done, false_start
  );

endinterface

// File: rtl/bit_sample_counter_mod_counter.sv
// Modulo-N up counter with enable and synchronous clear; wrap_o flags the enabled N-1 -> 0 step.
module mod_counter #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/bit_sample_counter.sv
// Oversampling bit-timing engine: times a frame from the start edge and emits
// mid-bit sample, bit-boundary, frame-complete and false-start strobes.
module bit_sample_counter
  import bsc_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 10
) (
  input logic                 clk,
  input logic                 reset,
  bit_sample_counter_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] PRE_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_oversample
    $error("bit_sample_counter: OVERSAMPLE outside legal range");
  end
  if (FRAME_BITS < FRAME_BITS_MIN || FRAME_BITS > FRAME_BITS_MAX) begin : g_bad_frame_bits
    $error("bit_sample_counter: FRAME_BITS outside legal range");
  end

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             sample_q, sample_d;
  logic             bitDone_q, bitDone_d;
  logic             frameDone_q, frameDone_d;
  logic             falseStart_q, falseStart_d;
  logic [CNT_W-1:0] phase;
  logic [BIT_W-1:0] bitNum;
  logic             runTick, midHit, falseHit, cntClr, phaseWrap, frameEnd;

  // The tick that lands phase on MID is the one that produces the sample strobe.
  assign runTick  = (state_q == RUN) && bus.tick && !bus.abort;
  assign midHit   = runTick && (phase == PRE_MID);
  assign falseHit = midHit && (bitNum == '0) && bus.rxd;
  assign cntClr   = bus.abort || falseHit;

  mod_counter #(.N(OVERSAMPLE), .W(CNT_W)) u_phase (
    .clk     (clk),
    .reset   (reset),
    .en_i    (runTick),
    .clr_i   (cntClr),
    .count_o (phase),
    .wrap_o  (phaseWrap)
  );

  mod_counter #(.N(FRAME_BITS), .W(BIT_W)) u_bit (
    .clk     (clk),
    .reset   (reset),
    .en_i    (phaseWrap),
    .clr_i   (cntClr),
    .count_o (bitNum),
    .wrap_o  (frameEnd)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    sample_d     = 1'b0;
    bitDone_d    = 1'b0;
    frameDone_d  = 1'b0;
    falseStart_d = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          if (falseHit) begin
            falseStart_d = 1'b1;
            state_d      = IDLE;
            busy_d       = 1'b0;
          end else if (midHit) begin
            sample_d = 1'b1;
          end
          if (phaseWrap) begin
            bitDone_d = 1'b1;
          end
          if (frameEnd) begin
            frameDone_d = 1'b1;
            state_d     = IDLE;
            busy_d      = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      sample_q     <= 1'b0;
      bitDone_q    <= 1'b0;
      frameDone_q  <= 1'b0;
      falseStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      sample_q     <= sample_d;
      bitDone_q    <= bitDone_d;
      frameDone_q  <= frameDone_d;
      falseStart_q <= falseStart_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.phase       = phase;
  assign bus.bit_num     = bitNum;
  assign bus.sample      = sample_q;
  assign bus.bit_done    = bitDone_q;
  assign bus.frame_done  = frameDone_q;
  assign bus.false_start = falseStart_q;

endmodule
